// File: rtl/bitonic_sort_pipe_pkg.sv
// bitonic_sort_pipe_pkg
// Shared definitions for the pipelined bitonic sorter.
//   elem_t       : element type at the default element width
//   numStages    : number of compare-exchange stages for a given log2(N)
//   stagePhase   : bitonic phase p of a flat stage index
//   stagePass    : pass j inside that phase (partner distance 2^j)
//   partnerDist  : 2^j
//   lowIndex     : lower element index of compare pair c at pass j
//   descBit      : 1 when the pair containing element k sorts descending in phase p
package bitonic_sort_pipe_pkg;

  localparam int ELEM_W_DEFAULT = 4;
  typedef logic [ELEM_W_DEFAULT-1:0] elem_t;

  function automatic int numStages(input int logN);
    return logN * (logN + 1) / 2;
  endfunction

  // Stages are numbered phase by phase; phase p has passes j = p down to 0.
  function automatic int stagePhase(input int s, input int logN);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 0; p < logN; p++) begin
      for (int j = p; j >= 0; j--) begin
        if (cnt == s) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  function automatic int stagePass(input int s, input int logN);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 0; p < logN; p++) begin
      for (int j = p; j >= 0; j--) begin
        if (cnt == s) res = j;
        cnt++;
      end
    end
    return res;
  endfunction

  function automatic int partnerDist(input int j);
    return 1 << j;
  endfunction

  // Insert a zero at bit j of the pair number to get the lower partner.
  function automatic int lowIndex(input int c, input int j);
    return ((c >> j) << (j + 1)) | (c & ((1 << j) - 1));
  endfunction

  // Blocks of size 2^(p+1) alternate direction; in the last phase every
  // index is below N so bit log_N is zero and the whole vector ascends.
  function automatic logic descBit(input int p, input int k);
    return ((k >> (p + 1)) & 1) != 0;
  endfunction

endpackage

// File: rtl/bitonic_sort_pipe_cas.sv
// bitonic_cas
// Combinational two-element compare-exchange.
//   a_i, b_i  : elements at the lower / upper index of the pair
//   dir_i     : 0 = ascending (first_o <= second_o), 1 = descending
//   first_o   : element for the lower index
//   second_o  : element for the upper index
// Equal elements are passed through unswapped.
module bitonic_cas #(
  parameter int elements_width = 4
) (
  input  logic [elements_width-1:0] a_i,
  input  logic [elements_width-1:0] b_i,
  input  logic                      dir_i,
  output logic [elements_width-1:0] first_o,
  output logic [elements_width-1:0] second_o
);

  logic swap;

  always_comb begin
    swap     = dir_i ? (a_i < b_i) : (a_i > b_i);
    first_o  = swap ? b_i : a_i;
    second_o = swap ? a_i : b_i;
  end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// bitonic_sort_pipe
// Fully pipelined bitonic sorter, one N-element vector per cycle, ascending.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake, in_ready = global advance
//   in                   : N elements, element 0 at the MSB end
//   out_valid / out_ready: output handshake
//   out                  : sorted vector, element 0 smallest
// Bank 0 registers the raw input; banks 1..S each hold the result of one
// compare-exchange layer, so a vector accepted at edge t is on out after
// edge t+S. All banks advance together or hold together.
module bitonic_sort_pipe
  import bitonic_sort_pipe_pkg::*;
#(
  parameter int N              = 8,
  parameter int log_N          = 3,
  parameter int elements_width = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [0:N*elements_width-1]  in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [0:N*elements_width-1]  out
);

  localparam int W = elements_width;
  localparam int S = numStages(log_N);

  logic [W-1:0] stageData_q [0:S][0:N-1];
  logic [W-1:0] stageData_d [0:S][0:N-1];
  logic [S:0]   stageValid_q;
  logic [S:0]   stageValid_d;
  logic [W-1:0] casOut      [1:S][0:N-1];
  logic         adv;

  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = adv;
  assign out_valid = stageValid_q[S];

  generate
    for (genvar s = 0; s < S; s++) begin : g_stage
      localparam int P = stagePhase(s, log_N);
      localparam int J = stagePass(s, log_N);
      for (genvar c = 0; c < N / 2; c++) begin : g_pair
        localparam int LO = lowIndex(c, J);
        localparam int HI = LO + partnerDist(J);
        bitonic_cas #(
          .elements_width(W)
        ) u_cas (
          .a_i     (stageData_q[s][LO]),
          .b_i     (stageData_q[s][HI]),
          .dir_i   (descBit(P, LO)),
          .first_o (casOut[s+1][LO]),
          .second_o(casOut[s+1][HI])
        );
      end
    end
  endgenerate

  // Bank 0 takes the raw input; every later bank takes the compare-exchange
  // output of its predecessor, valid bit shifting alongside.
  always_comb begin
    stageValid_d    = '0;
    stageValid_d[0] = in_valid;
    for (int k = 0; k < N; k++) begin
      stageData_d[0][k] = in[k*W +: W];
    end
    for (int s = 1; s <= S; s++) begin
      stageValid_d[s] = stageValid_q[s-1];
      for (int k = 0; k < N; k++) begin
        stageData_d[s][k] = casOut[s][k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stageValid_q <= '0;
      for (int s = 0; s <= S; s++) begin
        for (int k = 0; k < N; k++) begin
          stageData_q[s][k] <= '0;
        end
      end
    end else if (adv) begin
      stageValid_q <= stageValid_d;
      for (int s = 0; s <= S; s++) begin
        for (int k = 0; k < N; k++) begin
          stageData_q[s][k] <= stageData_d[s][k];
        end
      end
    end
  end

  always_comb begin
    out = '0;
    for (int k = 0; k < N; k++) begin
      out[k*W +: W] = stageData_q[S][k];
    end
  end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// tb_bitonic_sort_pipe
// Directed and random stimulus for bitonic_sort_pipe (N=8, W=4), checked
// against a plain bubble-sort reference and a queue of expected outputs.
module tb_bitonic_sort_pipe;
  import bitonic_sort_pipe_pkg::*;

  localparam int N  = 8;
  localparam int LN = 3;
  localparam int W  = 4;
  localparam int VW = N * W;
  localparam int LAT = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [0:VW-1] inVec;
  logic          out_valid;
  logic          out_ready;
  logic [0:VW-1] outVec;

  int errors = 0;
  int checks = 0;
  int acceptCount = 0;
  int outCount = 0;
  logic [0:VW-1] refQ[$];
  logic          lastStall = 1'b0;
  logic [0:VW-1] heldOut = '0;

  bitonic_sort_pipe #(
    .N(N),
    .log_N(LN),
    .elements_width(W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in       (inVec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (outVec)
  );

  always #5 clk = ~clk;

  // Reference: unpack, bubble sort ascending, repack with element 0 at MSB.
  function automatic logic [0:VW-1] refSort(input logic [0:VW-1] v);
    int e[N];
    int t;
    logic [0:VW-1] r;
    for (int k = 0; k < N; k++) e[k] = int'(v[k*W +: W]);
    for (int a = 0; a < N; a++) begin
      for (int b = 0; b < N - 1 - a; b++) begin
        if (e[b] > e[b+1]) begin
          t = e[b];
          e[b] = e[b+1];
          e[b+1] = t;
        end
      end
    end
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = elem_t'(e[k]);
    return r;
  endfunction

  function automatic logic [0:VW-1] randVec();
    logic [0:VW-1] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = elem_t'($urandom_range(0, 15));
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [0:VW-1] d);
    in_valid = v;
    inVec    = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer a new random vector only after the previous one was taken; a
  // vector refused by in_ready is held unchanged.
  task automatic stepDriver(input logic offer);
    logic fire;
    fire = in_valid && in_ready;
    cyc();
    if (fire || !in_valid) applyStimulus(offer, randVec());
  endtask

  task automatic directedVector(input string tag, input logic [0:VW-1] vin, input logic [0:VW-1] vexp);
    int seen;
    int arrival;
    seen = 0;
    arrival = -1;
    applyStimulus(1'b1, vin);
    cyc();
    applyStimulus(1'b0, vin);
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (out_valid) begin
        seen++;
        if (arrival < 0) begin
          arrival = k;
          checkOutput({tag, "_value"}, 64'(outVec), 64'(vexp));
        end
      end
    end
    checkOutput({tag, "_latency"}, 64'(arrival), 64'(LAT));
    checkOutput({tag, "_pulses"}, 64'(seen), 64'd1);
  endtask

  task automatic drainAll(input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int k = 0; k < 50 && refQ.size() != 0; k++) cyc();
    cyc();
    checkOutput({tag, "_empty"}, 64'(refQ.size()), 64'd0);
    checkOutput({tag, "_count"}, 64'(outCount), 64'(acceptCount));
  endtask

  // Scoreboard: sampled mid-cycle, mirrors what the next rising edge transfers.
  always @(negedge clk) begin
    if (reset) begin
      refQ.delete();
      acceptCount = outCount;
      lastStall = 1'b0;
    end else begin
      if (lastStall) checkOutput("hold_stable", 64'(outVec), 64'(heldOut));
      if (in_valid && in_ready) begin
        refQ.push_back(refSort(inVec));
        acceptCount++;
      end
      if (out_valid && out_ready) begin
        if (refQ.size() == 0) checkOutput("extra_out", 64'd1, 64'd0);
        else checkOutput("sorted_out", 64'(outVec), 64'(refQ.pop_front()));
        outCount++;
      end
      lastStall = out_valid && !out_ready;
      heldOut = outVec;
    end
  end

  initial begin
    int ones;
    int first;
    int cnt;
    logic [0:VW-1] snap;

    reset = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, '0);
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out", 64'(outVec), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

    directedVector("reversed", 32'h7654_3210, 32'h0123_4567);
    directedVector("dup_extreme", 32'hF0F0_0F0F, 32'h0000_FFFF);
    directedVector("all_equal", 32'h3333_3333, 32'h3333_3333);

    // Back-to-back stream of 20 vectors; outputs expected on cycles 6..25.
    ones = 0;
    first = -1;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(i < 20, randVec());
      cyc();
      if (out_valid) begin
        ones++;
        if (first < 0) first = i;
      end
    end
    checkOutput("stream_count", 64'(ones), 64'd20);
    checkOutput("stream_first", 64'(first), 64'(LAT));
    drainAll("stream");

    // Backpressure with the pipe full.
    applyStimulus(1'b1, randVec());
    for (int i = 0; i < 10; i++) stepDriver(1'b1);
    out_ready = 1'b0;
    snap = outVec;
    checkOutput("stall_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      stepDriver(1'b1);
      checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      checkOutput("stall_out_held", 64'(outVec), 64'(snap));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) stepDriver(1'b0);
    drainAll("backpressure");

    // Bubbles with random downstream readiness.
    applyStimulus(1'b1, randVec());
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      stepDriver((i % 2) == 1);
    end
    drainAll("bubbles");

    // Reset with four vectors in flight.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, randVec());
      cyc();
    end
    applyStimulus(1'b0, '0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_out", 64'(outVec), 64'd0);
    checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (out_valid) cnt++;
    end
    checkOutput("midreset_no_emit", 64'(cnt), 64'd0);
    drainAll("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
